// File: rtl/module_gray_input_if.sv
// Switch-side and decoded-side signals of the Gray input front end.
// The bench drives through master; the decoder block connects as slave.
interface module_gray_input_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic             clr_error;
  logic [WIDTH-1:0] binary_code;
  logic             code_valid;
  logic             gray_error;
  logic             error_sticky;
  logic             busy;

  modport master (
    output gray_in, clr_error,
    input  binary_code, code_valid, gray_error, error_sticky, busy
  );

  modport slave (
    input  gray_in, clr_error,
    output binary_code, code_valid, gray_error, error_sticky, busy
  );
endinterface

// File: rtl/module_gray_input.sv
// Gray decoder front end: 2-FF synchronizer, debounce FSM, Gray-to-binary
// conversion and detection of multi-bit jumps between accepted codes.
module module_gray_input #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  module_gray_input_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_e;

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  state_e           state_q;
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] bin_q;
  logic [CW-1:0]    cnt_q;
  logic             valid_q;
  logic             err_q;
  logic             sticky_q;

  logic [WIDTH-1:0] cand_diff;
  logic             multi_bit;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int unsigned k = 1; k < WIDTH; k++) begin
      b[WIDTH-1-k] = b[WIDTH-k] ^ g[WIDTH-1-k];
    end
    return b;
  endfunction

  // x & (x-1) is non-zero exactly when x has two or more bits set.
  always_comb begin
    cand_diff = cand_q ^ stable_q;
    multi_bit = (cand_diff & (cand_diff - WIDTH'(1))) != '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= bus.gray_in;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (bus.clr_error) begin
        sticky_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (sync_q != stable_q) begin
            cand_q  <= sync_q;
            cnt_q   <= '0;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (sync_q == cand_q) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= COMMIT;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (sync_q == stable_q) begin
            state_q <= IDLE;
          end else begin
            cand_q <= sync_q;
            cnt_q  <= '0;
          end
        end
        COMMIT: begin
          stable_q <= cand_q;
          bin_q    <= g2b(cand_q);
          valid_q  <= 1'b1;
          err_q    <= multi_bit;
          // Placed after the clear so a simultaneous set takes priority.
          if (multi_bit) begin
            sticky_q <= 1'b1;
          end
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.binary_code  = bin_q;
  assign bus.code_valid   = valid_q;
  assign bus.gray_error   = err_q;
  assign bus.error_sticky = sticky_q;
  assign bus.busy         = (state_q == COUNT);

endmodule

// File: tb/tb_module_gray_input.sv
// Directed bench for module_gray_input: a table of accepted-code transitions
// plus hand-written glitch, bounce, error-clear and mid-debounce reset sequences.
module tb_module_gray_input;

  localparam int unsigned W   = 4;
  localparam int unsigned D   = 16;
  localparam int          LAT = D + 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  module_gray_input_if #(.WIDTH(W)) bus ();

  module_gray_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks    = 0;
  int n_fail      = 0;
  int valid_count = 0;

  always @(posedge clk) begin
    if (bus.code_valid === 1'b1) valid_count++;
  end

  typedef struct {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
    logic         err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edge 1 is the first rising edge after the input change.
  task automatic wait_commit(input int max_edges, output int edges,
                             output logic b3, output logic b_last);
    logic found;
    found  = 1'b0;
    edges  = 0;
    b3     = 1'bx;
    b_last = 1'bx;
    while (!found && edges < max_edges) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 3)       b3     = bus.busy;
      if (edges == LAT - 1) b_last = bus.busy;
      if (bus.code_valid === 1'b1) found = 1'b1;
    end
    check("commit_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bin"},    {28'd0, bus.binary_code}, 32'd0);
    check({tag, "_valid"},  {31'd0, bus.code_valid},   32'd0);
    check({tag, "_err"},    {31'd0, bus.gray_error},   32'd0);
    check({tag, "_sticky"}, {31'd0, bus.error_sticky}, 32'd0);
    check({tag, "_busy"},   {31'd0, bus.busy},         32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   edges;
    int   vc0;
    logic b3, bl, seen;

    vecs[0] = '{gray: 4'b0001, bin: 4'b0001, err: 1'b0};
    vecs[1] = '{gray: 4'b0011, bin: 4'b0010, err: 1'b0};
    vecs[2] = '{gray: 4'b0010, bin: 4'b0011, err: 1'b0};
    vecs[3] = '{gray: 4'b0110, bin: 4'b0100, err: 1'b0};
    vecs[4] = '{gray: 4'b1110, bin: 4'b1011, err: 1'b0};
    vecs[5] = '{gray: 4'b0000, bin: 4'b0000, err: 1'b1};
    vecs[6] = '{gray: 4'b1101, bin: 4'b1001, err: 1'b1};
    vecs[7] = '{gray: 4'b1111, bin: 4'b1010, err: 1'b0};
    vecs[8] = '{gray: 4'b0000, bin: 4'b0000, err: 1'b1};

    // Test 1: reset, idle input held
    bus.gray_in   = '0;
    bus.clr_error = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_zero("in_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_no_valid", valid_count, 32'd0);
    check_zero("idle");

    // Table of accepted transitions, starting from stable 0000
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.gray_in = vecs[i].gray;
      wait_commit(LAT + 20, edges, b3, bl);
      check($sformatf("v%0d_latency", i), edges, LAT);
      check($sformatf("v%0d_bin", i), {28'd0, bus.binary_code}, {28'd0, vecs[i].bin});
      check($sformatf("v%0d_err", i), {31'd0, bus.gray_error}, {31'd0, vecs[i].err});
      check($sformatf("v%0d_sticky", i), {31'd0, bus.error_sticky}, {31'd0, vecs[i].err});
      check($sformatf("v%0d_busy_e3", i), {31'd0, b3}, 32'd1);
      check($sformatf("v%0d_busy_commit", i), {31'd0, bl}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid_pulse", i), {31'd0, bus.code_valid}, 32'd0);
      check($sformatf("v%0d_err_pulse", i), {31'd0, bus.gray_error}, 32'd0);
      if (vecs[i].err) begin
        @(negedge clk) bus.clr_error = 1'b1;
        @(negedge clk) bus.clr_error = 1'b0;
        check($sformatf("v%0d_sticky_clr", i), {31'd0, bus.error_sticky}, 32'd0);
      end
    end

    // Test 5: multi-bit jump, sticky hold and clear
    @(negedge clk) bus.gray_in = 4'b1101;
    wait_commit(LAT + 20, edges, b3, bl);
    check("t5_latency", edges, LAT);
    check("t5_bin", {28'd0, bus.binary_code}, 32'h9);
    check("t5_err", {31'd0, bus.gray_error}, 32'd1);
    repeat (10) @(negedge clk);
    check("t5_sticky_hold", {31'd0, bus.error_sticky}, 32'd1);
    bus.clr_error = 1'b1;
    @(negedge clk) bus.clr_error = 1'b0;
    check("t5_sticky_clr", {31'd0, bus.error_sticky}, 32'd0);

    // Set and clear in the same cycle: set wins
    @(negedge clk) bus.gray_in = 4'b0000;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk) bus.clr_error = 1'b1;
    @(posedge clk);
    #1;
    check("t5b_valid", {31'd0, bus.code_valid}, 32'd1);
    check("t5b_err", {31'd0, bus.gray_error}, 32'd1);
    check("t5b_set_wins", {31'd0, bus.error_sticky}, 32'd1);
    @(negedge clk) bus.clr_error = 1'b0;
    @(negedge clk);
    check("t5b_sticky_after", {31'd0, bus.error_sticky}, 32'd1);

    // Stable 0001 as base for glitch and bounce tests
    bus.gray_in = 4'b0001;
    wait_commit(LAT + 20, edges, b3, bl);
    check("base_bin", {28'd0, bus.binary_code}, 32'h1);
    check("base_err", {31'd0, bus.gray_error}, 32'd0);
    check("base_sticky_kept", {31'd0, bus.error_sticky}, 32'd1);

    // Test 3: short glitch is rejected
    repeat (3) @(negedge clk);
    vc0  = valid_count;
    seen = 1'b0;
    bus.gray_in = 4'b0011;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy === 1'b1) seen = 1'b1;
    end
    bus.gray_in = 4'b0001;
    repeat (30) @(negedge clk);
    check("t3_busy_seen", {31'd0, seen}, 32'd1);
    check("t3_busy_low", {31'd0, bus.busy}, 32'd0);
    check("t3_no_valid", valid_count - vc0, 32'd0);
    check("t3_bin", {28'd0, bus.binary_code}, 32'h1);

    // Test 4: bouncing input, then settled level
    vc0 = valid_count;
    for (int i = 0; i < 6; i++) begin
      bus.gray_in = (i % 2 == 0) ? 4'b0011 : 4'b0111;
      repeat (3) @(negedge clk);
    end
    check("t4_busy_bounce", {31'd0, bus.busy}, 32'd1);
    check("t4_no_early_valid", valid_count - vc0, 32'd0);
    bus.gray_in = 4'b0011;
    wait_commit(LAT + 20, edges, b3, bl);
    check("t4_latency", edges, LAT);
    check("t4_bin", {28'd0, bus.binary_code}, 32'h2);
    check("t4_err", {31'd0, bus.gray_error}, 32'd0);
    repeat (10) @(negedge clk);
    check("t4_one_valid", valid_count - vc0, 32'd1);

    // Test 6: reset during debounce, release with 1111 present
    bus.gray_in = 4'b1111;
    repeat (11) @(posedge clk);
    #1;
    check("t6_busy_before", {31'd0, bus.busy}, 32'd1);
    check("t6_sticky_before", {31'd0, bus.error_sticky}, 32'd1);
    rst_n = 1'b0;
    #1 check_zero("t6_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_commit(LAT + 20, edges, b3, bl);
    check("t6_latency", edges, LAT);
    check("t6_bin", {28'd0, bus.binary_code}, 32'hA);
    check("t6_err", {31'd0, bus.gray_error}, 32'd1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
